serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Receive side of the single-bit serial link whose transmitter drives an idle-high line (output resets to 1'b1) and sends framed words.
- Samples the serial line on a per-bit strobe, detects the start bit, and shifts in WIDTH data bits LSB first.
- Checks the stop bit and presents the assembled word on a valid/ready output port with a one-entry holding buffer.
- Sits between the serial pin logic and the parallel datapath consumer.

Parameters:
- WIDTH, 8, data bits per frame, legal range 1..32.
- IDLE_VAL, 1'b1, line level when idle; the start bit is ~IDLE_VAL and the stop bit is IDLE_VAL.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- sdi  input  1  serial data line.
- bit_en  input  1  bit strobe; sdi is sampled only in cycles where bit_en=1.
- out_data  output  WIDTH  received word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid&&out_ready.
- frame_err  output  1  one-cycle pulse: bad stop bit.
- overrun  output  1  sticky flag: a completed frame was dropped because the buffer was full. Cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; out_data=0; out_valid=0; frame_err=0; overrun=0; bit counter=0; shift register=0.
  - Reset mid-frame abandons the frame; no output is produced.
- States IDLE, DATA, STOP (PARITY is added when the optional feature is compiled in).
- IDLE:
  - On bit_en && sdi==~IDLE_VAL, go to DATA with counter=0.
  - sdi==IDLE_VAL stays in IDLE.
- DATA:
  - Each bit_en shifts sdi into bit position counter; bit 0 is received first.
  - After WIDTH strobes, go to STOP.
- STOP, on bit_en:
  - If sdi==IDLE_VAL the frame is good.
  - Otherwise pulse frame_err for exactly one cycle (the cycle after the sampling edge) and discard the word.
  - Either way, return to IDLE.
  - A start bit on the strobe immediately after STOP is recognised; frames can be back-to-back with no idle gap.
- bit_en=0 cycles hold all state; sdi is ignored.
- Output buffer:
  - Good frame with out_valid=0, or out_valid=1 && out_ready=1 in the same cycle: load out_data and set out_valid=1 on the same edge.
  - Good frame with out_valid=1 && out_ready=0: keep the old word, drop the new one, set overrun=1.
  - Accept with no new frame: out_valid=0 next cycle. out_data holds its last value.
  - out_data is stable while out_valid=1 && !out_ready.
- Latency: out_valid rises on the clk edge of the stop-bit strobe; the word is visible the cycle after that strobe.
- The counter is sized clog2(WIDTH+1). It wraps to 0 on entry to DATA.
- rst has priority over every other event.

Optional Feature:
- Macro: SERIAL_FRAME_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one extra bit.
  - Even parity: XOR of the data bits and the parity bit must be 0.
  - Add output parity_err (1 bit), a one-cycle pulse aligned with where out_valid would rise.
  - A parity-error frame is discarded; it does not set overrun.
  - A stop error in the same frame pulses both frame_err and parity_err.
- Undefined: no PARITY state and no parity_err port; the frame is start + WIDTH + stop.

Test Plan:
1. Reset/idle: hold rst 2 cycles, then sdi=1, bit_en=1 for 20 cycles -> out_valid=0, frame_err=0, overrun=0, out_data=0.
2. Single frame, WIDTH=8, bit_en every cycle, out_ready=1: send 0,(1,0,1,1,0,0,1,0),1 -> out_data=8'h4D, out_valid high exactly 1 cycle, the cycle after the stop strobe.
3. Sparse strobe: bit_en every 3rd cycle, frame 8'hA5, sdi toggled randomly in non-strobe cycles -> out_data=8'hA5, no errors.
4. Stop error: frame 8'h3C with stop bit 0 -> frame_err one-cycle pulse, out_valid stays 0, then the next good frame 8'h01 is received normally.
5. Backpressure: out_ready=0, two back-to-back frames 8'h11 then 8'h22 -> out_data stays 8'h11, overrun=1. Raising out_ready clears out_valid next cycle; overrun stays 1 until rst.
6. Reset mid-frame: assert rst after 4 data bits, release, send 8'hF0 -> out_data=8'hF0, no stale bits; with the parity macro, a wrong parity bit gives a parity_err pulse and out_valid=0.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, stop bit, one-entry valid/ready buffer.
// Define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_frame_rx #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdi,
    input  logic             bit_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun
`ifdef SERIAL_FRAME_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             par_bad_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic             parity_err_q;
`endif

    // Shift right with the new bit entering at the MSB, so after WIDTH strobes
    // the first-received bit sits at bit 0.
    always_comb begin
        shift_d = (shift_q >> 1) | (WIDTH'(sdi) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            par_bad_q    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (bit_en) begin
                case (state_q)
                    IDLE: begin
                        if (sdi != IDLE_VAL) begin
                            state_q   <= DATA;
                            cnt_q     <= '0;
                            par_bad_q <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    PARITY: begin
                        par_bad_q <= (^shift_q) ^ sdi;
                        state_q   <= STOP;
                    end
`endif
                    STOP: begin
                        state_q <= IDLE;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        parity_err_q <= par_bad_q;
`endif
                        if (sdi != IDLE_VAL) begin
                            frame_err_q <= 1'b1;
                        end else if (!par_bad_q) begin
                            // A word leaving this cycle frees the buffer for the new one.
                            if (!out_valid_q || out_ready) begin
                                out_data_q  <= shift_q;
                                out_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
